// File: rtl/seq_fsm_counter.sv
// Programmable-table sequence generator: steps forward/reverse over an active length
// with a wrap pulse. Define SEQ_BOUNCE_EN to add the `bounce` ping-pong turnaround mode.
module seq_fsm_counter #(
    parameter int                     WIDTH    = 3,
    parameter int                     DEPTH    = 4,
    parameter logic [WIDTH*DEPTH-1:0] SEQ_INIT = 12'hED0,
    localparam int                    AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [AW-1:0]    len_m1,
`ifdef SEQ_BOUNCE_EN
    input  logic             bounce,
`endif
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic [AW-1:0]    idx,
    output logic             wrap
);

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] ONE      = AW'(1);

    logic [WIDTH-1:0] tbl_r [DEPTH];
    logic [AW-1:0]    idx_r;
    logic             wrap_r;
    logic [WIDTH-1:0] count_r;

    logic [AW-1:0]    last_s;
    logic [AW-1:0]    step_s;
    logic [AW-1:0]    wrap_idx_s;
    logic [AW-1:0]    turn_idx_s;
    logic [AW-1:0]    idx_next_s;
    logic             hit_s;
    logic             wrap_next_s;
    logic             wr_ok_s;
    logic             bnc_s;
    logic [WIDTH-1:0] count_next_s;
    dir_e             dir_s;

`ifdef SEQ_BOUNCE_EN
    logic             rev_r;
    logic             rev_next_s;
`endif

    // Next-position, wrap and bypassed next-count computation
    always_comb begin
        last_s  = (len_m1 > LAST_MAX) ? LAST_MAX : len_m1;
        wr_ok_s = wr_en && (wr_addr <= LAST_MAX);
`ifdef SEQ_BOUNCE_EN
        bnc_s   = bounce;
        dir_s   = dir_e'(dir ^ (bounce & rev_r));
`else
        bnc_s   = 1'b0;
        dir_s   = dir_e'(dir);
`endif
        hit_s      = 1'b0;
        step_s     = idx_r;
        wrap_idx_s = ZERO;
        turn_idx_s = ZERO;
        // An index stranded above a shrunken length always turns back to last.
        case (dir_s)
            DIR_FWD: begin
                hit_s      = (idx_r >= last_s);
                step_s     = idx_r + ONE;
                wrap_idx_s = ZERO;
                turn_idx_s = (last_s == ZERO) ? ZERO :
                             (idx_r > last_s) ? last_s : (last_s - ONE);
            end
            DIR_REV: begin
                hit_s      = (idx_r == ZERO) || (idx_r > last_s);
                step_s     = idx_r - ONE;
                wrap_idx_s = last_s;
                turn_idx_s = (last_s == ZERO) ? ZERO :
                             (idx_r > last_s) ? last_s : ONE;
            end
            default: begin
                hit_s      = 1'b0;
                step_s     = idx_r;
                wrap_idx_s = ZERO;
                turn_idx_s = ZERO;
            end
        endcase

        if (!en) begin
            idx_next_s  = idx_r;
            wrap_next_s = 1'b0;
        end else if (hit_s) begin
            idx_next_s  = bnc_s ? turn_idx_s : wrap_idx_s;
            wrap_next_s = 1'b1;
        end else begin
            idx_next_s  = step_s;
            wrap_next_s = 1'b0;
        end

`ifdef SEQ_BOUNCE_EN
        rev_next_s = bounce ? (rev_r ^ (en & hit_s)) : 1'b0;
`endif

        // A same-edge write to the destination entry must be visible immediately.
        if (wr_ok_s && (wr_addr == idx_next_s)) begin
            count_next_s = wr_data;
        end else begin
            count_next_s = tbl_r[idx_next_s];
        end
    end

    // Sequence table storage, restored to the reset image on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= SEQ_INIT[i*WIDTH +: WIDTH];
            end
        end else if (wr_ok_s) begin
            tbl_r[wr_addr] <= wr_data;
        end
    end

    // Sequencer state with registered count/idx/wrap outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r   <= ZERO;
            wrap_r  <= 1'b0;
            count_r <= SEQ_INIT[WIDTH-1:0];
`ifdef SEQ_BOUNCE_EN
            rev_r   <= 1'b0;
`endif
        end else begin
            idx_r   <= idx_next_s;
            wrap_r  <= wrap_next_s;
            count_r <= count_next_s;
`ifdef SEQ_BOUNCE_EN
            rev_r   <= rev_next_s;
`endif
        end
    end

    assign count = count_r;
    assign idx   = idx_r;
    assign wrap  = wrap_r;

endmodule

// File: tb/tb_seq_fsm_counter.sv
// Self-checking bench for seq_fsm_counter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_seq_fsm_counter;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en, dir, wr_en, bnc;
    logic [AW-1:0]    len_m1, wr_addr, idx;
    logic [WIDTH-1:0] wr_data, count;
    logic             wrap;

    logic             b_en, b_dir, b_wr_en, b_wrap;
    logic [1:0]       b_len, b_wr_addr, b_idx;
    logic [2:0]       b_wr_data, b_count;

    int n_chk  = 0;
    int n_fail = 0;

    int m_tbl [DEPTH];
    int m_pos;
    int m_wrap;
    int m_rev;

    always #5 clk = ~clk;

    seq_fsm_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEQ_INIT(12'hED0)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .len_m1(len_m1),
`ifdef SEQ_BOUNCE_EN
        .bounce(bnc),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .idx(idx), .wrap(wrap)
    );

    // Three-entry instance: exercises length clamping and out-of-range write addresses.
    seq_fsm_counter #(.WIDTH(3), .DEPTH(3), .SEQ_INIT(9'b011_010_000)) dut3 (
        .clk(clk), .rst(rst), .en(b_en), .dir(b_dir), .len_m1(b_len),
`ifdef SEQ_BOUNCE_EN
        .bounce(1'b0),
`endif
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .count(b_count), .idx(b_idx), .wrap(b_wrap)
    );

    typedef struct {
        logic       e;
        logic       d;
        logic [1:0] l;
        logic       w;
        logic [1:0] a;
        logic [2:0] dat;
        logic [2:0] ec;
        logic [1:0] ei;
        logic       ew;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input int e, d, l, w, a, dat, ec, ei, ew);
        vec_t v;
        v.e = e[0]; v.d = d[0]; v.l = l[1:0]; v.w = w[0]; v.a = a[1:0];
        v.dat = dat[2:0]; v.ec = ec[2:0]; v.ei = ei[1:0]; v.ew = ew[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick_raw();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        m_tbl[0] = 0; m_tbl[1] = 2; m_tbl[2] = 3; m_tbl[3] = 7;
        m_pos = 0; m_wrap = 0; m_rev = 0;
    endtask

    // Reference: wrap = circular arithmetic over 0..last; bounce = reflect at the ends.
    task automatic model_step();
        int  last, np, n;
        bit  fw;
        last = (int'(len_m1) > DEPTH - 1) ? DEPTH - 1 : int'(len_m1);
        n = last + 1;
        np = m_pos;
        m_wrap = 0;
        if (en) begin
            fw = ((dir ^ (bnc && (m_rev != 0))) == 1'b0);
            if (fw) begin
                np = (m_pos > last) ? 0 : (m_pos + 1) % n;
                m_wrap = (np == 0) ? 1 : 0;
            end else begin
                np = (m_pos > last) ? last : (m_pos + last) % n;
                m_wrap = (m_pos == 0 || m_pos > last) ? 1 : 0;
            end
            if (m_wrap == 1 && bnc) begin
                m_rev = (m_rev == 0) ? 1 : 0;
                if (last == 0)          np = 0;
                else if (m_pos > last)  np = last;
                else                    np = fw ? last - 1 : 1;
            end
        end
        if (!bnc) m_rev = 0;
        m_pos = np;
        if (wr_en && int'(wr_addr) < DEPTH) m_tbl[wr_addr] = int'(wr_data);
    endtask

    task automatic tick_model();
        model_step();
        tick_raw();
        chk("rnd_count", count, m_tbl[m_pos]);
        chk("rnd_idx", idx, m_pos);
        chk("rnd_wrap", wrap, m_wrap);
    endtask

    task automatic step3(input string tag, input int ec, input int ei, input int ew);
        tick_raw();
        chk({tag, "_count"}, count, ec);
        chk({tag, "_idx"}, idx, ei);
        chk({tag, "_wrap"}, wrap, ew);
    endtask

    initial begin
        vecs[0]  = mk(1,0,3,0,0,0, 2,1,0);
        vecs[1]  = mk(1,0,3,0,0,0, 3,2,0);
        vecs[2]  = mk(1,0,3,0,0,0, 7,3,0);
        vecs[3]  = mk(1,0,3,0,0,0, 0,0,1);
        vecs[4]  = mk(1,0,3,0,0,0, 2,1,0);
        vecs[5]  = mk(0,0,3,0,0,0, 2,1,0);
        vecs[6]  = mk(0,1,3,0,0,0, 2,1,0);
        vecs[7]  = mk(1,1,3,0,0,0, 0,0,0);
        vecs[8]  = mk(1,1,3,0,0,0, 7,3,1);
        vecs[9]  = mk(1,1,3,0,0,0, 3,2,0);
        vecs[10] = mk(1,1,3,0,0,0, 2,1,0);
        vecs[11] = mk(0,0,3,1,2,5, 2,1,0);
        vecs[12] = mk(1,0,3,0,0,0, 5,2,0);
        vecs[13] = mk(1,0,3,1,3,6, 6,3,0);
        vecs[14] = mk(1,0,3,0,0,0, 0,0,1);
        vecs[15] = mk(0,0,3,1,0,4, 4,0,0);
        vecs[16] = mk(1,0,1,0,0,0, 2,1,0);
        vecs[17] = mk(1,0,1,0,0,0, 4,0,1);
        vecs[18] = mk(1,0,1,0,0,0, 2,1,0);
        vecs[19] = mk(1,0,1,0,0,0, 4,0,1);
        vecs[20] = mk(1,0,3,0,0,0, 2,1,0);
        vecs[21] = mk(1,0,3,0,0,0, 5,2,0);
        vecs[22] = mk(1,0,3,0,0,0, 6,3,0);
        vecs[23] = mk(1,0,0,0,0,0, 4,0,1);
        vecs[24] = mk(1,0,0,0,0,0, 4,0,1);
        vecs[25] = mk(1,1,0,0,0,0, 4,0,1);
        vecs[26] = mk(1,0,3,0,0,0, 2,1,0);
        vecs[27] = mk(1,0,3,0,0,0, 5,2,0);
        vecs[28] = mk(1,1,1,0,0,0, 2,1,1);

        rst = 1'b0; en = 1'b1; dir = 1'b0; len_m1 = 2'd3; bnc = 1'b0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 3'd0;
        b_en = 1'b0; b_dir = 1'b0; b_len = 2'd2; b_wr_en = 1'b0; b_wr_addr = 2'd0; b_wr_data = 3'd0;
        #3;
        chk("reset_count", count, 0);
        chk("reset_idx", idx, 0);
        chk("reset_wrap", wrap, 0);
        #9 rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 29; i++) begin
            en = vecs[i].e; dir = vecs[i].d; len_m1 = vecs[i].l;
            wr_en = vecs[i].w; wr_addr = vecs[i].a; wr_data = vecs[i].dat;
            tick_raw();
            chk($sformatf("vec%0d_count", i), count, vecs[i].ec);
            chk($sformatf("vec%0d_idx", i), idx, vecs[i].ei);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].ew);
        end

        // Async reset mid-cycle while count=7; written entries must revert
        en = 1'b0; dir = 1'b0; len_m1 = 2'd3; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 3'd7;
        step3("pre_wr", 2, 1, 0);
        en = 1'b1; wr_en = 1'b0;
        step3("pre_run1", 5, 2, 0);
        step3("pre_run2", 7, 3, 0);
        #3 rst = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_idx", idx, 0);
        chk("async_wrap", wrap, 0);
        #2 rst = 1'b1;
        step3("post_rst1", 2, 1, 0);
        step3("post_rst2", 3, 2, 0);
        step3("post_rst3", 7, 3, 0);

        // Three-entry instance: len clamp and ignored wr_addr=3
        en = 1'b0;
        b_en = 1'b1; b_len = 2'd3; b_wr_en = 1'b1; b_wr_addr = 2'd3; b_wr_data = 3'd5;
        tick_raw();
        chk("d3_c1", b_count, 2); chk("d3_i1", b_idx, 1);
        b_wr_en = 1'b0;
        tick_raw();
        chk("d3_c2", b_count, 3); chk("d3_i2", b_idx, 2); chk("d3_w2", b_wrap, 0);
        tick_raw();
        chk("d3_c3", b_count, 0); chk("d3_i3", b_idx, 0); chk("d3_w3", b_wrap, 1);
        tick_raw();
        chk("d3_c4", b_count, 2); chk("d3_i4", b_idx, 1);
        b_en = 1'b0;

`ifdef SEQ_BOUNCE_EN
        // Ping-pong: 0,2,3,7,3,2,0,2 then wrap mode resumes
        rst = 1'b0; #2 rst = 1'b1;
        en = 1'b1; dir = 1'b0; len_m1 = 2'd3; bnc = 1'b1;
        step3("bnc1", 2, 1, 0);
        step3("bnc2", 3, 2, 0);
        step3("bnc3", 7, 3, 0);
        step3("bnc4", 3, 2, 1);
        step3("bnc5", 2, 1, 0);
        step3("bnc6", 0, 0, 0);
        step3("bnc7", 2, 1, 1);
        bnc = 1'b0;
        step3("bnc8", 3, 2, 0);
        step3("bnc9", 7, 3, 0);
        step3("bnc10", 0, 0, 1);
`endif

        // Randomized run against the behavioural model
        rst = 1'b0; en = 1'b0; wr_en = 1'b0; bnc = 1'b0;
        tick_raw();
        rst = 1'b1;
        model_init();
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 7) == 0) len_m1 = 2'($urandom_range(0, 3));
`ifdef SEQ_BOUNCE_EN
            if ($urandom_range(0, 15) == 0) bnc = ~bnc;
`endif
            wr_en   = ($urandom_range(0, 5) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 3'($urandom_range(0, 7));
            tick_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
